// File: rtl/cg_pkg.sv
// rtl/cg_pkg.sv - shared types and sizing helper for the clock-gate controller
// Purpose: FSM state encoding and the width helper for the shared idle/wake counter.
package cg_pkg;

  typedef enum logic [1:0] {
    CG_RUN,
    CG_IDLE,
    CG_GATED,
    CG_WAKE
  } cg_state_e;

  // Width needed to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
    int max_cycles;
    max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/cg_sat_counter.sv
// rtl/cg_sat_counter.sv - saturating up-counter
// Purpose: counts cycles with inc high and sticks at all-ones.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset, clears count
//   inc   in  increment enable
//   count out current count (WIDTH bits)
module cg_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - activity-based ICG enable controller
// Purpose: drops gate_en after IDLE_CYCLES idle samples, restores the clock on a
// wake_req/wake_ack handshake with a WAKE_CYCLES settle delay, counts gated cycles.
// Ports:
//   clk          in  free-running clock
//   rst          in  synchronous active-high reset
//   busy         in  gated domain has work in flight
//   wake_req     in  level request for a running clock, held until wake_ack
//   force_on     in  override, keeps the clock ungated
//   gate_en      out registered ICG enable, 1 = clock runs
//   wake_ack     out one-cycle pulse, clock running and stable
//   gated        out 1 while in GATED
//   sleep_cycles out saturating count of GATED cycles
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  output logic              gate_en,
  output logic              wake_ack,
  output logic              gated,
  output logic [STAT_W-1:0] sleep_cycles
);

  import cg_pkg::*;

  localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);

  cg_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             gate_en_q;
  logic             wake_ack_q;
  logic             gated_q;
  logic             ack_done_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CG_RUN;
      cnt_q      <= '0;
      gate_en_q  <= 1'b1;
      wake_ack_q <= 1'b0;
      gated_q    <= 1'b0;
      ack_done_q <= 1'b0;
    end else begin
      wake_ack_q <= 1'b0;
      if (!wake_req) begin
        ack_done_q <= 1'b0;
      end

      case (state_q)
        CG_RUN, CG_IDLE: begin
          if (busy || wake_req || force_on) begin
            state_q   <= CG_RUN;
            cnt_q     <= '0;
            gate_en_q <= 1'b1;
            // Clock is already running, so an unserved request is acked directly.
            if (wake_req && !ack_done_q) begin
              wake_ack_q <= 1'b1;
              ack_done_q <= 1'b1;
            end
          end else if (cnt_d == IDLE_LAST) begin
            // cnt is always 0 in RUN, so IDLE_CYCLES=1 gates from RUN directly.
            state_q   <= CG_GATED;
            cnt_q     <= '0;
            gate_en_q <= 1'b0;
            gated_q   <= 1'b1;
          end else begin
            state_q <= CG_IDLE;
            cnt_q   <= cnt_d;
          end
        end

        CG_GATED: begin
          // busy is ignored here: the domain is frozen and cannot change it.
          if (force_on) begin
            state_q   <= CG_RUN;
            cnt_q     <= '0;
            gate_en_q <= 1'b1;
            gated_q   <= 1'b0;
          end else if (wake_req) begin
            state_q   <= CG_WAKE;
            cnt_q     <= '0;
            gate_en_q <= 1'b1;
            gated_q   <= 1'b0;
          end
        end

        CG_WAKE: begin
          if (force_on) begin
            // Pending request is picked up by the RUN ack path next cycle.
            state_q <= CG_RUN;
            cnt_q   <= '0;
          end else if (cnt_d == WAKE_LAST) begin
            state_q    <= CG_RUN;
            cnt_q      <= '0;
            wake_ack_q <= 1'b1;
            ack_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q   <= CG_RUN;
          cnt_q     <= '0;
          gate_en_q <= 1'b1;
          gated_q   <= 1'b0;
        end
      endcase
    end
  end

  cg_sat_counter #(
    .WIDTH(STAT_W)
  ) u_sleep_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (gated_q),
    .count(sleep_cycles)
  );

  assign gate_en  = gate_en_q;
  assign wake_ack = wake_ack_q;
  assign gated    = gated_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - directed self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       wake_req;
  logic       force_on;
  logic       gate_en;
  logic       wake_ack;
  logic       gated;
  logic [7:0] sleep_cycles;

  int n_assert;
  int n_fail;

  clock_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .STAT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .wake_req    (wake_req),
    .force_on    (force_on),
    .gate_en     (gate_en),
    .wake_ack    (wake_ack),
    .gated       (gated),
    .sleep_cycles(sleep_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural latch-based ICG driven by gate_en.
  logic en_lat;
  logic gclk;
  always @(clk or gate_en) begin
    if (!clk) en_lat = gate_en;
  end
  assign gclk = clk & en_lat;

  logic mon_en;
  logic rise_valid;
  time  rise_t;
  int   bad_pulses;
  int   n_pulses;
  int   bad_toggles;
  int   n_toggles;

  always @(posedge gclk) begin
    if (mon_en) begin
      rise_t     = $time;
      rise_valid = 1'b1;
      if (clk !== 1'b1) bad_pulses++;
    end
  end

  always @(negedge gclk) begin
    if (mon_en && rise_valid) begin
      if (($time - rise_t) != 5 || clk !== 1'b0) bad_pulses++;
      n_pulses++;
    end
  end

  always @(gate_en) begin
    if (mon_en) begin
      n_toggles++;
      if ((($time % 10) != 5) || (clk !== 1'b1)) bad_toggles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; busy = 1'b1; wake_req = 1'b0; force_on = 1'b0;
    tick();
    tick();
    n_assert++;
    if (gate_en !== 1'b1) begin n_fail++; $display("FAIL reset_gate_en got=%b exp=1", gate_en); end
    n_assert++;
    if (wake_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wake_ack got=%b exp=0", wake_ack); end
    n_assert++;
    if (gated !== 1'b0) begin n_fail++; $display("FAIL reset_gated got=%b exp=0", gated); end
    n_assert++;
    if (sleep_cycles !== 8'd0) begin n_fail++; $display("FAIL reset_sleep got=%0d exp=0", sleep_cycles); end
    rst = 1'b0;
  endtask

  task automatic test_idle_entry();
    busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_assert++;
      if (gate_en !== (i < 4)) begin
        n_fail++; $display("FAIL idle_entry_gate_en edge=%0d got=%b exp=%b", i, gate_en, (i < 4));
      end
    end
    n_assert++;
    if (gated !== 1'b1) begin n_fail++; $display("FAIL idle_entry_gated got=%b exp=1", gated); end
    n_assert++;
    if (sleep_cycles !== 8'd0) begin n_fail++; $display("FAIL idle_entry_sleep0 got=%0d exp=0", sleep_cycles); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_assert++;
      if (sleep_cycles !== 8'(k)) begin
        n_fail++; $display("FAIL idle_entry_sleep got=%0d exp=%0d", sleep_cycles, k);
      end
    end
  endtask

  task automatic test_force_on();
    force_on = 1'b1;
    tick();
    n_assert++;
    if (gate_en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b0) begin
      n_fail++; $display("FAIL force_on_exit got gate_en=%b gated=%b ack=%b exp 1/0/0", gate_en, gated, wake_ack);
    end
    tick();
    n_assert++;
    if (gate_en !== 1'b1 || wake_ack !== 1'b0) begin
      n_fail++; $display("FAIL force_on_hold got gate_en=%b ack=%b exp 1/0", gate_en, wake_ack);
    end
    force_on = 1'b0;
    busy     = 1'b1;
    tick();
  endtask

  task automatic test_idle_abort();
    busy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_assert++;
      if (gate_en !== 1'b1) begin n_fail++; $display("FAIL idle_abort_pre edge=%0d got=%b exp=1", i, gate_en); end
    end
    busy = 1'b1;
    tick();
    n_assert++;
    if (gate_en !== 1'b1) begin n_fail++; $display("FAIL idle_abort_busy got=%b exp=1", gate_en); end
    busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_assert++;
      if (gate_en !== (i < 4)) begin
        n_fail++; $display("FAIL idle_abort_regate edge=%0d got=%b exp=%b", i, gate_en, (i < 4));
      end
    end
  endtask

  task automatic test_wake();
    wake_req = 1'b1;
    tick();
    n_assert++;
    if (gate_en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b0) begin
      n_fail++; $display("FAIL wake_edge_n got gate_en=%b gated=%b ack=%b exp 1/0/0", gate_en, gated, wake_ack);
    end
    tick();
    n_assert++;
    if (wake_ack !== 1'b0) begin n_fail++; $display("FAIL wake_edge_n1_ack got=%b exp=0", wake_ack); end
    tick();
    n_assert++;
    if (wake_ack !== 1'b1 || gate_en !== 1'b1) begin
      n_fail++; $display("FAIL wake_edge_n2 got ack=%b gate_en=%b exp 1/1", wake_ack, gate_en);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_assert++;
      if (wake_ack !== 1'b0 || gate_en !== 1'b1) begin
        n_fail++; $display("FAIL wake_held cyc=%0d got ack=%b gate_en=%b exp 0/1", i, wake_ack, gate_en);
      end
    end
    wake_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_assert++;
      if (gate_en !== (i < 4)) begin
        n_fail++; $display("FAIL wake_regate edge=%0d got=%b exp=%b", i, gate_en, (i < 4));
      end
    end
  endtask

  task automatic test_reset_mid_wake();
    wake_req = 1'b1;
    tick();
    tick();
    // The ack would land on the next edge; reset must suppress it.
    rst = 1'b1; wake_req = 1'b0; busy = 1'b1;
    tick();
    n_assert++;
    if (gate_en !== 1'b1 || wake_ack !== 1'b0 || gated !== 1'b0 || sleep_cycles !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wake got gate_en=%b ack=%b gated=%b sleep=%0d exp 1/0/0/0",
               gate_en, wake_ack, gated, sleep_cycles);
    end
    rst = 1'b0;
    tick();
    n_assert++;
    if (wake_ack !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wake_late_ack got=%b exp=0", wake_ack); end
  endtask

  task automatic test_ungated_ack();
    wake_req = 1'b1;
    tick();
    n_assert++;
    if (wake_ack !== 1'b1) begin n_fail++; $display("FAIL ungated_ack got=%b exp=1", wake_ack); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_assert++;
      if (wake_ack !== 1'b0) begin n_fail++; $display("FAIL ungated_ack_once cyc=%0d got=%b exp=0", i, wake_ack); end
    end
    wake_req = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_assert++;
    if (gated !== 1'b1) begin n_fail++; $display("FAIL sat_gated got=%b exp=1", gated); end
    for (int i = 0; i < 254; i++) tick();
    n_assert++;
    if (sleep_cycles !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", sleep_cycles); end
    tick();
    n_assert++;
    if (sleep_cycles !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", sleep_cycles); end
    for (int i = 0; i < 45; i++) tick();
    n_assert++;
    if (sleep_cycles !== 8'd255 || gated !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold got sleep=%0d gated=%b exp 255/1", sleep_cycles, gated);
    end
  endtask

  task automatic test_glitch();
    bad_pulses  = 0;
    n_pulses    = 0;
    bad_toggles = 0;
    n_toggles   = 0;
    rise_valid  = 1'b0;
    mon_en      = 1'b1;
    for (int i = 0; i < 500; i++) begin
      busy     = ($urandom_range(0, 3) == 0);
      wake_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    busy     = 1'b0;
    wake_req = 1'b0;
    tick();
    mon_en = 1'b0;
    n_assert++;
    if (bad_pulses !== 0) begin n_fail++; $display("FAIL glitch_gclk_pulses bad=%0d exp=0", bad_pulses); end
    n_assert++;
    if (bad_toggles !== 0) begin n_fail++; $display("FAIL glitch_gate_en_toggle bad=%0d exp=0", bad_toggles); end
    n_assert++;
    if (n_pulses == 0 || n_toggles == 0) begin
      n_fail++; $display("FAIL glitch_activity pulses=%0d toggles=%0d exp nonzero", n_pulses, n_toggles);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    rise_valid = 1'b0;
    rise_t     = 0;
    rst        = 1'b1;
    busy       = 1'b1;
    wake_req   = 1'b0;
    force_on   = 1'b0;
    test_reset();
    test_idle_entry();
    test_force_on();
    test_idle_abort();
    test_wake();
    test_reset_mid_wake();
    test_ungated_ack();
    test_saturation();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
